// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage in front of the main decoder. Holds the PC and issues word
//   fetches to instruction memory. The address phase is req/gnt and the data
//   phase is rvalid, with at most one request outstanding. Returned words go
//   into a small shift FIFO. The registered FIFO head is presented to decode
//   with a valid/ready handshake. A redirect flushes buffered and in-flight
//   words.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   imem_req/imem_addr/imem_gnt     fetch address phase
//   imem_rvalid/imem_rdata          fetch data phase
//   redirect_valid/redirect_pc      PC redirect from execute (low bits ignored)
//   if_valid/if_ready               handshake to decode
//   Instruction/InstrPC/Opcode      head of buffer; NOP/0 when empty
//
// state | meaning
// REQ   | no request outstanding; request issued when the buffer has room
// WAIT  | one request granted, waiting for its rvalid
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     Instruction,
  output logic [XLEN-1:0] InstrPC,
  output logic [6:0]      Opcode
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [31:0]     instr_d [FIFO_DEPTH];
  logic [XLEN-1:0] ipc_q   [FIFO_DEPTH];
  logic [XLEN-1:0] ipc_d   [FIFO_DEPTH];

  logic req_ok, fire, pop, push, outstanding;
  int   wr_idx;

  // Room is judged on the count before any same-cycle pop, so the single
  // outstanding word always has a slot when it returns.
  assign req_ok    = (state_q == S_REQ) && (count_q < DEPTH_C);
  assign imem_req  = rst_n && req_ok;
  assign imem_addr = pc_q;
  assign fire      = req_ok && imem_gnt;

  assign if_valid    = (count_q != '0);
  assign Instruction = if_valid ? instr_q[0] : NOP;
  assign InstrPC     = if_valid ? ipc_q[0] : '0;
  assign Opcode      = Instruction[6:0];

  assign pop  = if_valid && if_ready;
  assign push = (state_q == S_WAIT) && imem_rvalid && !discard_q && !redirect_valid;

  // A response is still owed to us after this edge: its data must be dropped.
  assign outstanding = ((state_q == S_WAIT) && !imem_rvalid) || fire;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    discard_d = discard_q;
    count_d   = count_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    wr_idx    = pop ? int'(count_q) - 1 : int'(count_q);

    case (state_q)
      S_REQ: begin
        if (fire) begin
          pend_pc_d = pc_q;
          pc_d      = pc_q + XLEN'(4);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        instr_d[i] = instr_q[i+1];
        ipc_d[i]   = ipc_q[i+1];
      end
      count_d = count_q - CW'(1);
    end

    if (push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (i == wr_idx) begin
          instr_d[i] = imem_rdata;
          ipc_d[i]   = pend_pc_q;
        end
      end
      count_d = count_d + CW'(1);
    end

    if (redirect_valid) begin
      count_d = '0;
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      if (outstanding) begin
        discard_d = 1'b1;
        state_d   = S_WAIT;
      end else begin
        state_d   = S_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      discard_q <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, if_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, Instruction, InstrPC;
  logic [6:0]  Opcode;

  logic        g2 = 1'b0, rv2 = 1'b0;
  logic [31:0] rd2 = '0;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, ipc2;
  logic [6:0]  op2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .Instruction(Instruction), .InstrPC(InstrPC), .Opcode(Opcode)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(g2),
    .imem_rvalid(rv2), .imem_rdata(rd2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(valid2), .if_ready(1'b1),
    .Instruction(instr2), .InstrPC(ipc2), .Opcode(op2)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[24:0], 7'h37 ^ a[8:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    logic [31:0] d;
    d = data_of(pc);
    chk({tag, ".valid"}, {31'b0, if_valid}, 32'd1);
    chk({tag, ".pc"}, InstrPC, pc);
    chk({tag, ".instr"}, Instruction, d);
    chk({tag, ".opcode"}, {25'b0, Opcode}, {25'b0, d[6:0]});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, {31'b0, if_valid}, 32'd0);
    chk({tag, ".instr"}, Instruction, 32'h0000_0013);
    chk({tag, ".opcode"}, {25'b0, Opcode}, 32'h13);
    chk({tag, ".pc"}, InstrPC, 32'h0);
  endtask

  task automatic tick(input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    if_ready    = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    g2 = 1'b0; rv2 = 1'b0; rd2 = '0;
    redirect_valid = 1'b0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset values while rst_n is held low
    tick(0, 0, 0, 0);
    chk("rst.req", {31'b0, imem_req}, 32'd0);
    chk("rst.addr", imem_addr, 32'h0);
    chk_empty("rst");
    do_reset();

    // 1: streaming fetch, one word every two cycles
    for (int k = 0; k < 3; k++) begin
      chk_fetch("t1.fetch", 1'b1, 32'(4 * k));
      if (k > 0) chk_head("t1.head", 32'(4 * (k - 1)));
      tick(1, 0, 0, 1);
      chk_fetch("t1.wait", 1'b0, 32'h0);
      tick(0, 1, data_of(32'(4 * k)), 1);
    end
    chk_head("t1.last", 32'h8);

    // 2: decode stalls, buffer fills to two words and fetch stops
    do_reset();
    chk_fetch("t2.f0", 1'b1, 32'h0);
    tick(1, 0, 0, 0);
    tick(0, 1, data_of(32'h0), 0);
    chk_fetch("t2.f4", 1'b1, 32'h4);
    tick(1, 0, 0, 0);
    tick(0, 1, data_of(32'h4), 0);
    for (int k = 0; k < 10; k++) begin
      chk_fetch("t2.full", 1'b0, 32'h0);
      chk("t2.hold_pc", InstrPC, 32'h0);
      tick(1, 0, 0, 0);
    end
    chk_head("t2.d0", 32'h0);
    tick(0, 0, 0, 1);
    chk_head("t2.d1", 32'h4);
    chk_fetch("t2.resume", 1'b1, 32'h8);
    tick(1, 0, 0, 1);
    chk("t2.drained", {31'b0, if_valid}, 32'd0);
    tick(0, 1, data_of(32'h8), 1);
    chk_head("t2.d2", 32'h8);

    // 3: grant withheld, request and address stay put
    do_reset();
    tick(1, 0, 0, 1);
    tick(0, 1, data_of(32'h0), 1);
    for (int k = 0; k < 3; k++) begin
      chk_fetch("t3.stall", 1'b1, 32'h4);
      tick(0, 0, 0, 1);
    end
    chk_fetch("t3.granted", 1'b1, 32'h4);
    tick(1, 0, 0, 1);
    chk_fetch("t3.wait", 1'b0, 32'h0);
    tick(0, 1, data_of(32'h4), 1);
    chk_head("t3.word", 32'h4);

    // 4: redirect during WAIT; the late word is stale and dropped
    do_reset();
    tick(1, 0, 0, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick(0, 0, 0, 1);
    redirect_valid = 1'b0;
    chk_fetch("t4.wait", 1'b0, 32'h0);
    tick(0, 1, data_of(32'h0), 1);
    chk("t4.dropped", {31'b0, if_valid}, 32'd0);
    chk_fetch("t4.target", 1'b1, 32'h100);
    tick(1, 0, 0, 1);
    tick(0, 1, data_of(32'h100), 1);
    chk_head("t4.first", 32'h100);

    // 5: PC wraps past the top of the address space
    do_reset();
    chk("t5.req0", {31'b0, req2}, 32'd1);
    chk("t5.addr0", addr2, 32'hFFFF_FFF8);
    g2 = 1'b1;
    tick(0, 0, 0, 0);
    g2 = 1'b0; rv2 = 1'b1; rd2 = data_of(32'hFFFF_FFF8);
    tick(0, 0, 0, 0);
    rv2 = 1'b0;
    chk("t5.addr1", addr2, 32'hFFFF_FFFC);
    chk("t5.pc1", ipc2, 32'hFFFF_FFF8);
    chk("t5.instr1", instr2, data_of(32'hFFFF_FFF8));
    chk("t5.op1", {25'b0, op2}, {25'b0, data_of(32'hFFFF_FFF8) & 32'h7F});
    chk("t5.valid1", {31'b0, valid2}, 32'd1);
    g2 = 1'b1;
    tick(0, 0, 0, 0);
    g2 = 1'b0; rv2 = 1'b1; rd2 = data_of(32'hFFFF_FFFC);
    tick(0, 0, 0, 0);
    rv2 = 1'b0;
    chk("t5.req2", {31'b0, req2}, 32'd1);
    chk("t5.addr2", addr2, 32'h0);
    chk("t5.pc2", ipc2, 32'hFFFF_FFFC);

    // 6: reset asserted in WAIT with a word buffered
    do_reset();
    tick(1, 0, 0, 0);
    tick(0, 1, data_of(32'h0), 0);
    tick(1, 0, 0, 0);
    chk_head("t6.buffered", 32'h0);
    rst_n = 1'b0;
    #1;
    chk_empty("t6.in_reset");
    chk("t6.req_rst", {31'b0, imem_req}, 32'd0);
    tick(0, 0, 0, 1);
    rst_n = 1'b1;
    #1;
    tick(0, 1, data_of(32'h4), 1);
    chk("t6.late_ignored", {31'b0, if_valid}, 32'd0);
    chk_fetch("t6.restart", 1'b1, 32'h0);
    tick(1, 0, 0, 1);
    tick(0, 1, data_of(32'h0), 1);
    chk_head("t6.refetch", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
